// File: rtl/pcie_ctrl_fsm.sv
// pcie_ctrl_fsm: control FSM that sequences the PCIe datapath and supplies FIFO thresholds
module pcie_ctrl_fsm #(
  parameter int LENGTH = 4,
  parameter int NUM_FIFOS = 5,
  parameter int UMBRAL_DEFAULT = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 init,
  input  logic [LENGTH-1:0]    umbral_MF_in,
  input  logic [LENGTH-1:0]    umbral_VC_in,
  input  logic [LENGTH-1:0]    umbral_D_in,
  input  logic [NUM_FIFOS-1:0] fifo_empties,
  input  logic [NUM_FIFOS-1:0] fifo_errors,
  output logic [LENGTH-1:0]    umbral_MF_out,
  output logic [LENGTH-1:0]    umbral_VC_out,
  output logic [LENGTH-1:0]    umbral_D_out,
  output logic [2:0]           state,
  output logic                 idle_out,
  output logic                 active_out,
  output logic [NUM_FIFOS-1:0] error_out
);
  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_ERROR  = 3'd4
  } state_t;
  localparam logic [LENGTH-1:0] UDEF = LENGTH'(UMBRAL_DEFAULT);
  state_t              state_q;
  logic [LENGTH-1:0]   mf_q, vc_q, d_q;
  logic                idle_q, active_q;
  logic [NUM_FIFOS-1:0] err_q;
  function automatic logic [LENGTH-1:0] fix(input logic [LENGTH-1:0] v);
    return (v == '0) ? UDEF : v;
  endfunction
  // State, thresholds and flags; idle/active are decoded from the next state so they align with it
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ST_RESET;
      mf_q     <= UDEF;
      vc_q     <= UDEF;
      d_q      <= UDEF;
      idle_q   <= 1'b0;
      active_q <= 1'b0;
      err_q    <= '0;
    end else begin
      idle_q   <= 1'b0;
      active_q <= 1'b0;
      case (state_q)
        ST_RESET: state_q <= ST_INIT;
        ST_INIT: begin
          mf_q <= fix(umbral_MF_in);
          vc_q <= fix(umbral_VC_in);
          d_q  <= fix(umbral_D_in);
          if (!init) begin
            state_q <= ST_IDLE;
            idle_q  <= 1'b1;
          end
        end
        ST_IDLE, ST_ACTIVE: begin
          if (|fifo_errors) begin
            state_q <= ST_ERROR;
            err_q   <= err_q | fifo_errors;
          end else if (init) begin
            state_q <= ST_INIT;
          end else if (&fifo_empties) begin
            state_q <= ST_IDLE;
            idle_q  <= 1'b1;
          end else begin
            state_q  <= ST_ACTIVE;
            active_q <= 1'b1;
          end
        end
        ST_ERROR: err_q <= err_q | fifo_errors;
        default: begin
          state_q <= ST_RESET;
          mf_q    <= UDEF;
          vc_q    <= UDEF;
          d_q     <= UDEF;
          err_q   <= '0;
        end
      endcase
    end
  end
  assign state         = state_q;
  assign umbral_MF_out = mf_q;
  assign umbral_VC_out = vc_q;
  assign umbral_D_out  = d_q;
  assign idle_out      = idle_q;
  assign active_out    = active_q;
  assign error_out     = err_q;
endmodule

// File: tb/tb_pcie_ctrl_fsm.sv
// tb_pcie_ctrl_fsm: directed self-checking bench for pcie_ctrl_fsm
module tb_pcie_ctrl_fsm;
  logic       clk = 1'b0;
  logic       reset, init;
  logic [3:0] mf_in, vc_in, d_in, mf_out, vc_out, d_out;
  logic [4:0] empties, errors, err_out;
  logic [2:0] state;
  logic       idle, active;
  int         total = 0;
  int         passed = 0;
  pcie_ctrl_fsm dut (
    .clk(clk), .reset(reset), .init(init),
    .umbral_MF_in(mf_in), .umbral_VC_in(vc_in), .umbral_D_in(d_in),
    .fifo_empties(empties), .fifo_errors(errors),
    .umbral_MF_out(mf_out), .umbral_VC_out(vc_out), .umbral_D_out(d_out),
    .state(state), .idle_out(idle), .active_out(active), .error_out(err_out)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_umb(input string tag, input logic [3:0] m, input logic [3:0] v, input logic [3:0] d);
    chk({tag, "_mf"}, 32'(mf_out), 32'(m));
    chk({tag, "_vc"}, 32'(vc_out), 32'(v));
    chk({tag, "_d"}, 32'(d_out), 32'(d));
  endtask
  initial begin
    reset = 1'b0; init = 1'b0;
    mf_in = 4'd0; vc_in = 4'd0; d_in = 4'd0;
    empties = 5'b11111; errors = 5'b00000;
    step(); step();
    chk("rst_state", 32'(state), 0);
    chk("rst_idle", 32'(idle), 0);
    chk("rst_active", 32'(active), 0);
    chk("rst_err", 32'(err_out), 0);
    chk_umb("rst", 4'd1, 4'd1, 4'd1);
    reset = 1'b1; init = 1'b1; mf_in = 4'd3; vc_in = 4'd2; d_in = 5;
    step();
    chk("to_init", 32'(state), 1);
    chk_umb("pre_cap", 4'd1, 4'd1, 4'd1);
    step();
    chk("stay_init", 32'(state), 1);
    chk_umb("cap", 4'd3, 4'd2, 4'd5);
    vc_in = 4'd0;
    step();
    chk("zero_vc", 32'(vc_out), 1);
    vc_in = 4'd2; init = 1'b0;
    step();
    chk("to_idle", 32'(state), 2);
    chk("idle_flag", 32'(idle), 1);
    chk_umb("idle", 4'd3, 4'd2, 4'd5);
    mf_in = 4'd9;
    empties = 5'b11110;
    step();
    chk("to_active", 32'(state), 3);
    chk("act_flag", 32'(active), 1);
    chk("act_idle", 32'(idle), 0);
    chk("hold_mf", 32'(mf_out), 3);
    empties = 5'b11111;
    step();
    chk("back_idle", 32'(state), 2);
    chk("back_idle_flag", 32'(idle), 1);
    chk("back_idle_act", 32'(active), 0);
    empties = 5'b01111;
    step();
    chk("active2", 32'(state), 3);
    errors = 5'b01000; init = 1'b1;
    step();
    chk("err_wins", 32'(state), 4);
    chk("err_bits", 32'(err_out), 32'b01000);
    chk("err_active", 32'(active), 0);
    errors = 5'b00001; init = 1'b0;
    step();
    chk("err_or", 32'(err_out), 32'b01001);
    errors = 5'b00000; init = 1'b1; empties = 5'b00000;
    step();
    chk("err_terminal", 32'(state), 4);
    chk("err_sticky", 32'(err_out), 32'b01001);
    chk_umb("err", 4'd3, 4'd2, 4'd5);
    reset = 1'b0;
    #2;
    chk("rst_noedge", 32'(state), 4);
    chk("rst_noedge_err", 32'(err_out), 32'b01001);
    step();
    chk("mid_rst_state", 32'(state), 0);
    chk("mid_rst_err", 32'(err_out), 0);
    chk_umb("mid_rst", 4'd1, 4'd1, 4'd1);
    reset = 1'b1; init = 1'b0; mf_in = 4'd3; empties = 5'b11111;
    step();
    chk("re_init", 32'(state), 1);
    step();
    chk("re_idle", 32'(state), 2);
    chk_umb("re_idle", 4'd3, 4'd2, 4'd5);
    init = 1'b1; d_in = 4'd7;
    step();
    chk("reprog_state", 32'(state), 1);
    chk("reprog_d_hold", 32'(d_out), 5);
    errors = 5'b11111;
    step();
    chk("reprog_d", 32'(d_out), 7);
    chk("init_err_ignored", 32'(err_out), 0);
    chk("init_err_state", 32'(state), 1);
    errors = 5'b00000; init = 1'b0;
    step();
    chk("reprog_idle", 32'(state), 2);
    errors = 5'b10100;
    step();
    chk("idle_to_err", 32'(state), 4);
    chk("idle_err_bits", 32'(err_out), 32'b10100);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
